// File: rtl/mmio_pkg.sv
// Register map constants for the MMIO window overlaid on data RAM.
package mmio_pkg;

   localparam int unsigned WIN_SIZE = 8;

   localparam logic [2:0] OFF_BTN_STATE = 3'd0;
   localparam logic [2:0] OFF_LED       = 3'd1;
   localparam logic [2:0] OFF_BTN_EDGE  = 3'd2;
   localparam logic [2:0] OFF_TIMER     = 3'd3;

endpackage

// File: rtl/RAM.sv
// Word-addressed data RAM: synchronous write, combinational read.
module RAM #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter int unsigned DEPTH         = 4096
) (
   input  logic                     clk,
   input  logic                     wEn,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    dataIn,
   output logic [DATA_WIDTH-1:0]    dataOut
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wEn) begin
         mem[addr] <= dataIn;
      end
   end

   assign dataOut = mem[addr];

endmodule

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; rise pulses for one cycle on an accepted 0->1.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic            meta_q;
   logic            sync_q;
   logic            stable_q;
   logic            rise_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
         rise_q <= 1'b0;
         if (sync_q == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntMax) begin
            // Level has differed for DEBOUNCE_CYCLES consecutive edges: accept it.
            stable_q <= sync_q;
            rise_q   <= sync_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CntOne;
         end
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;

endmodule

// File: rtl/mmio_ram_hub.sv
// CPU data-memory front end: RAM storage with an 8-word MMIO window for buttons, LEDs and timer.
module mmio_ram_hub
   import mmio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDRESS_WIDTH   = 12,
   parameter int unsigned DEPTH           = 4096,
   parameter int unsigned MMIO_BASE       = 1000,
   parameter int unsigned NUM_BTN         = 5,
   parameter int unsigned NUM_LED         = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wEn,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    dataIn,
   output logic [DATA_WIDTH-1:0]    dataOut,
   input  logic [NUM_BTN-1:0]       BTN,
   output logic [NUM_LED-1:0]       LED
);

   localparam logic [ADDRESS_WIDTH-1:0] BaseAddr = ADDRESS_WIDTH'(MMIO_BASE);
   localparam logic [ADDRESS_WIDTH-1:0] WinSz    = ADDRESS_WIDTH'(WIN_SIZE);

   logic [ADDRESS_WIDTH-1:0] off_full;
   logic [2:0]               off;
   logic                     in_win;
   logic                     mmio_wr;
   logic                     ram_wen;
   logic [DATA_WIDTH-1:0]    ram_rdata;
   logic [DATA_WIDTH-1:0]    mmio_rdata;

   logic [NUM_BTN-1:0] btn_stable;
   logic [NUM_BTN-1:0] btn_rise;
   logic [NUM_BTN-1:0] edge_clr;
   logic [NUM_BTN-1:0] edge_q;
   logic [NUM_LED-1:0] led_q;
   logic [31:0]        timer_q;

   assign off_full = addr - BaseAddr;
   assign in_win   = (addr >= BaseAddr) && (off_full < WinSz);
   assign off      = off_full[2:0];
   assign mmio_wr  = wEn && in_win;
   assign ram_wen  = wEn && !in_win;

   RAM #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .DEPTH        (DEPTH)
   ) u_ram (
      .clk    (clk),
      .wEn    (ram_wen),
      .addr   (addr),
      .dataIn (dataIn),
      .dataOut(ram_rdata)
   );

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .reset (reset),
         .raw   (BTN[i]),
         .stable(btn_stable[i]),
         .rise  (btn_rise[i])
      );
   end

   assign edge_clr = (mmio_wr && off == OFF_BTN_EDGE) ? dataIn[NUM_BTN-1:0] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         led_q   <= '0;
         edge_q  <= '0;
         timer_q <= '0;
      end else begin
         if (mmio_wr && off == OFF_LED) begin
            led_q <= dataIn[NUM_LED-1:0];
         end
         // OR-ing the rise after the clear lets a same-cycle edge survive a W1C.
         edge_q <= (edge_q & ~edge_clr) | btn_rise;
         if (mmio_wr && off == OFF_TIMER) begin
            timer_q <= dataIn[31:0];
         end else begin
            timer_q <= timer_q + 32'd1;
         end
      end
   end

   always_comb begin
      mmio_rdata = '0;
      case (off)
         OFF_BTN_STATE: mmio_rdata[NUM_BTN-1:0] = btn_stable;
         OFF_LED:       mmio_rdata[NUM_LED-1:0] = led_q;
         OFF_BTN_EDGE:  mmio_rdata[NUM_BTN-1:0] = edge_q;
         OFF_TIMER:     mmio_rdata[31:0]        = timer_q;
         default:       mmio_rdata = '0;
      endcase
   end

   assign dataOut = in_win ? mmio_rdata : ram_rdata;
   assign LED     = led_q;

endmodule

// File: tb/tb_mmio_ram_hub.sv
// Directed bench for mmio_ram_hub: register-map table plus debounce, W1C, timer and reset sequences.
module tb_mmio_ram_hub;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 12;
   localparam int unsigned BASE = 1000;

   logic          clk = 1'b0;
   logic          reset;
   logic          wEn;
   logic [AW-1:0] addr;
   logic [DW-1:0] dataIn;
   logic [DW-1:0] dataOut;
   logic [4:0]    BTN;
   logic [15:0]   LED;

   int n_checks = 0;
   int n_errors = 0;

   mmio_ram_hub #(
      .DATA_WIDTH     (DW),
      .ADDRESS_WIDTH  (AW),
      .DEPTH          (4096),
      .MMIO_BASE      (BASE),
      .NUM_BTN        (5),
      .NUM_LED        (16),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .wEn    (wEn),
      .addr   (addr),
      .dataIn (dataIn),
      .dataOut(dataOut),
      .BTN    (BTN),
      .LED    (LED)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [31:0]   wdata;
      logic [31:0]   exp;
      logic [15:0]   exp_led;
      string         name;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      addr   = a;
      dataIn = d;
      wEn    = 1'b1;
      @(posedge clk);
      #2;
      wEn = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [31:0] q);
      wEn  = 1'b0;
      addr = a;
      #1;
      q = dataOut;
   endtask

   logic [31:0] q;
   logic [31:0] snap1001;

   initial begin
      vecs[0]  = '{1'b1, AW'(BASE + 1), 32'h0001A5A5, 32'h0000A5A5, 16'hA5A5, "led_wr"};
      vecs[1]  = '{1'b1, AW'(BASE + 0), 32'hFFFFFFFF, 32'h00000000, 16'hA5A5, "btn_state_ro"};
      vecs[2]  = '{1'b1, AW'(BASE + 4), 32'h12345678, 32'h00000000, 16'hA5A5, "rsvd4"};
      vecs[3]  = '{1'b1, AW'(BASE + 5), 32'hFFFFFFFF, 32'h00000000, 16'hA5A5, "rsvd5"};
      vecs[4]  = '{1'b1, AW'(BASE + 7), 32'hFFFFFFFF, 32'h00000000, 16'hA5A5, "rsvd7"};
      vecs[5]  = '{1'b1, AW'(BASE + 3), 32'h00000100, 32'h00000100, 16'hA5A5, "timer_ld"};
      vecs[6]  = '{1'b1, AW'(999),      32'h11111111, 32'h11111111, 16'hA5A5, "ram_below"};
      vecs[7]  = '{1'b1, AW'(1008),     32'h22222222, 32'h22222222, 16'hA5A5, "ram_above"};
      vecs[8]  = '{1'b1, AW'(0),        32'h33333333, 32'h33333333, 16'hA5A5, "ram_zero"};
      vecs[9]  = '{1'b1, AW'(BASE + 1), 32'h00012345, 32'h00002345, 16'h2345, "led_wr2"};
      vecs[10] = '{1'b1, AW'(BASE + 2), 32'hFFFFFFFF, 32'h00000000, 16'h2345, "edge_empty"};
      vecs[11] = '{1'b0, AW'(999),      32'h00000000, 32'h11111111, 16'h2345, "ram_hold"};

      reset  = 1'b1;
      wEn    = 1'b0;
      addr   = '0;
      dataIn = '0;
      BTN    = '0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // Straight after reset every MMIO word, timer included, reads 0.
      for (int k = 0; k < 8; k++) begin
         rd(AW'(BASE + k), q);
         chk($sformatf("rst_off%0d", k), q, 32'h0);
      end
      chk("rst_led", {16'h0, LED}, 32'h0);
      step();
      rd(AW'(BASE + 3), q);
      chk("timer_count1", q, 32'h1);

      wr(AW'(5), 32'hDEADBEEF);
      rd(AW'(5), q);
      chk("ram5", q, 32'hDEADBEEF);

      snap1001 = dut.u_ram.mem[BASE + 1];
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].we) wr(vecs[i].a, vecs[i].wdata);
         rd(vecs[i].a, q);
         chk(vecs[i].name, q, vecs[i].exp);
         chk({vecs[i].name, "_led"}, {16'h0, LED}, {16'h0, vecs[i].exp_led});
      end
      chk("ram1001_untouched", dut.u_ram.mem[BASE + 1], snap1001);

      // BTN[2] press: state after t+5, edge flag after t+6.
      BTN[2] = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         step();
         rd(AW'(BASE + 0), q);
         chk($sformatf("press_state_k%0d", k), q, (k >= 5) ? 32'h4 : 32'h0);
         rd(AW'(BASE + 2), q);
         chk($sformatf("press_edge_k%0d", k), q, (k >= 6) ? 32'h4 : 32'h0);
      end

      // 3-cycle glitch on BTN[0] must never be accepted.
      BTN[0] = 1'b1;
      repeat (3) step();
      BTN[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         rd(AW'(BASE + 0), q);
         chk($sformatf("glitch_state_k%0d", k), q, 32'h4);
      end
      rd(AW'(BASE + 2), q);
      chk("glitch_edge", q, 32'h4);

      wr(AW'(BASE + 2), 32'h0);
      rd(AW'(BASE + 2), q);
      chk("w1c_zero_keeps", q, 32'h4);
      wr(AW'(BASE + 2), 32'h4);
      rd(AW'(BASE + 2), q);
      chk("w1c_clear", q, 32'h0);

      BTN[2] = 1'b0;
      repeat (8) step();
      rd(AW'(BASE + 0), q);
      chk("release_state", q, 32'h0);
      rd(AW'(BASE + 2), q);
      chk("release_edge", q, 32'h0);

      // New press timed so the flag sets on the same edge as a W1C of bit 2.
      BTN[2] = 1'b1;
      repeat (6) step();
      rd(AW'(BASE + 2), q);
      chk("set_wins_pre", q, 32'h0);
      wr(AW'(BASE + 2), 32'h4);
      rd(AW'(BASE + 2), q);
      chk("set_wins", q, 32'h4);

      wr(AW'(BASE + 3), 32'hFFFFFFFE);
      rd(AW'(BASE + 3), q);
      chk("timer_v", q, 32'hFFFFFFFE);
      step();
      rd(AW'(BASE + 3), q);
      chk("timer_v1", q, 32'hFFFFFFFF);
      step();
      rd(AW'(BASE + 3), q);
      chk("timer_wrap", q, 32'h0);

      // BTN[1] pressed, counter at 2 when reset hits.
      BTN[1] = 1'b1;
      repeat (4) step();
      reset = 1'b1;
      step();
      rd(AW'(BASE + 0), q);
      chk("rst_mid_state", q, 32'h0);
      rd(AW'(BASE + 2), q);
      chk("rst_mid_edge", q, 32'h0);
      rd(AW'(BASE + 3), q);
      chk("rst_mid_timer", q, 32'h0);
      chk("rst_mid_led", {16'h0, LED}, 32'h0);
      rd(AW'(5), q);
      chk("rst_mid_ram5", q, 32'hDEADBEEF);
      rd(AW'(999), q);
      chk("rst_mid_ram999", q, 32'h11111111);
      reset = 1'b0;

      // Both held buttons re-debounce from scratch after release.
      repeat (5) step();
      rd(AW'(BASE + 0), q);
      chk("post_rst_state_r5", q, 32'h0);
      step();
      rd(AW'(BASE + 0), q);
      chk("post_rst_state_r6", q, 32'h6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
